// File: rtl/poly_pkg.sv
// Shared constants, types and capture state encoding for the result-capture slice.
// No logic; imported by the interface, the buffer and the capture top.
// Range checking is selected in the top with POLY_CAPTURE_RANGE_CHECK_EN.
package poly_pkg;

  localparam int N       = 1024;
  localparam int COEFF_W = 30;
  localparam int ADDR_W  = 10;

  typedef logic [COEFF_W-1:0] coeff_t;
  typedef logic [ADDR_W-1:0]  addr_t;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CAPTURE = 2'd1,
    ST_FULL    = 2'd2,
    ST_DRAIN   = 2'd3
  } cap_state_t;

endpackage

// File: rtl/poly_result_capture_if.sv
// Control, input stream, output stream and status bundle of the result-capture block.
// Pure wiring, no latency.
// Output stream is valid/ready; input stream has no backpressure.
interface poly_result_capture_if;
  import poly_pkg::*;

  logic   arm;
  logic   abort;
  logic   drain;
  coeff_t q;
  logic   in_valid;
  coeff_t in_data;
  logic   out_valid;
  logic   out_ready;
  coeff_t out_data;
  logic   out_last;
  logic   busy;
  logic   full;
  logic   done;
  logic   err_overflow;
  logic   err_range;
  addr_t  err_idx;

  // Producer/consumer side: drives commands and input words, accepts replayed words.
  modport master (
    output arm, abort, drain, q, in_valid, in_data, out_ready,
    input  out_valid, out_data, out_last, busy, full, done,
           err_overflow, err_range, err_idx
  );

  // Capture block side.
  modport slave (
    input  arm, abort, drain, q, in_valid, in_data, out_ready,
    output out_valid, out_data, out_last, busy, full, done,
           err_overflow, err_range, err_idx
  );

endinterface

// File: rtl/poly_result_capture_buffer.sv
// N x COEFF_W simple dual-port coefficient buffer (one write port, one read port).
// Registered read: data appears one cycle after re; output holds while re is low.
// No backpressure; the array has no reset so it maps onto block RAM.
module coeff_buffer_1r1w
  import poly_pkg::*;
(
  input  logic   clk,
  input  logic   we,
  input  addr_t  waddr,
  input  coeff_t wdata,
  input  logic   re,
  input  addr_t  raddr,
  output coeff_t rdata
);

  coeff_t mem [N];

  // Write port.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Read port: the output register only updates on re, so it doubles as the hold stage.
  always_ff @(posedge clk) begin
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/poly_result_capture.sv
// Captures one N-coefficient polynomial then replays it on a valid/ready stream.
// Latency: first out_valid 2 cycles after drain; 1 word/cycle while out_ready stays high.
// Backpressure: out_ready low freezes out_data/out_last; input side cannot be stalled.
// Optional range check against q is built when POLY_CAPTURE_RANGE_CHECK_EN is defined.
module poly_result_capture
  import poly_pkg::*;
(
  input logic                  clk,
  input logic                  reset,
  poly_result_capture_if.slave bus
);

  cap_state_t state, state_nxt;
  addr_t      wr_ptr;
  addr_t      rd_ptr;
  logic       rd_done;
  logic       out_valid_q;
  logic       out_last_q;
  logic       done_q;
  logic       err_overflow_q;
  coeff_t     rdata;

  logic wr_fire;
  logic wr_last;
  logic hs;
  logic hs_last;
  logic rd_issue;
  logic arm_accept;

  // Abort outranks every other event, so it gates all the fire strobes.
  assign wr_fire    = (state == ST_CAPTURE) && bus.in_valid && !bus.abort;
  assign wr_last    = wr_fire && (wr_ptr == ADDR_W'(N - 1));
  assign hs         = out_valid_q && bus.out_ready;
  assign hs_last    = hs && out_last_q;
  assign arm_accept = (state == ST_IDLE) && bus.arm && !bus.abort;
  // A new read is issued whenever the output stage is empty or being emptied this cycle.
  assign rd_issue   = (state == ST_DRAIN) && !rd_done && !bus.abort &&
                      (!out_valid_q || bus.out_ready);

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  // Next-state decode.
  always_comb begin
    state_nxt = state;
    if (bus.abort) begin
      state_nxt = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE:    if (bus.arm)   state_nxt = ST_CAPTURE;
        ST_CAPTURE: if (wr_last)   state_nxt = ST_FULL;
        ST_FULL:    if (bus.drain) state_nxt = ST_DRAIN;
        ST_DRAIN:   if (hs_last)   state_nxt = ST_IDLE;
        default:                   state_nxt = ST_IDLE;
      endcase
    end
  end

  // State-derived status outputs.
  always_comb begin
    bus.busy = (state != ST_IDLE);
    bus.full = (state == ST_FULL);
  end

  // Write and read pointers; rd_done marks that index N-1 has been fetched.
  always_ff @(posedge clk) begin
    if (reset || bus.abort) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      rd_done <= 1'b0;
    end else begin
      if (wr_fire) wr_ptr <= wr_ptr + 1'b1;
      if ((state == ST_FULL) && bus.drain) begin
        rd_ptr  <= '0;
        rd_done <= 1'b0;
      end else if (rd_issue) begin
        rd_ptr <= rd_ptr + 1'b1;
        if (rd_ptr == ADDR_W'(N - 1)) rd_done <= 1'b1;
      end
    end
  end

  // Output stage flags: valid follows each issued read, clears on an unrefilled handshake.
  always_ff @(posedge clk) begin
    if (reset || bus.abort) begin
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
    end else if (rd_issue) begin
      out_valid_q <= 1'b1;
      out_last_q  <= (rd_ptr == ADDR_W'(N - 1));
    end else if (hs) begin
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
    end
  end

  // Completion pulse in the first IDLE cycle after the final handshake.
  always_ff @(posedge clk) begin
    if (reset) done_q <= 1'b0;
    else       done_q <= hs_last && !bus.abort;
  end

  // Overflow flag: a word offered outside CAPTURE is dropped; setting wins over arm's clear.
  always_ff @(posedge clk) begin
    if (reset)                                          err_overflow_q <= 1'b0;
    else if (bus.in_valid && (state != ST_CAPTURE))     err_overflow_q <= 1'b1;
    else if (arm_accept)                                err_overflow_q <= 1'b0;
  end

`ifdef POLY_CAPTURE_RANGE_CHECK_EN
  logic  err_range_q;
  addr_t err_idx_q;

  // First out-of-range write latches its index; later ones leave it alone.
  always_ff @(posedge clk) begin
    if (reset) begin
      err_range_q <= 1'b0;
      err_idx_q   <= '0;
    end else if (arm_accept) begin
      err_range_q <= 1'b0;
      err_idx_q   <= '0;
    end else if (wr_fire && !err_range_q && (bus.in_data >= bus.q)) begin
      err_range_q <= 1'b1;
      err_idx_q   <= wr_ptr;
    end
  end

  assign bus.err_range = err_range_q;
  assign bus.err_idx   = err_idx_q;
`else
  logic unused_q;
  assign unused_q      = ^bus.q;
  assign bus.err_range = 1'b0;
  assign bus.err_idx   = '0;
`endif

  coeff_buffer_1r1w u_buf (
    .clk   (clk),
    .we    (wr_fire),
    .waddr (wr_ptr),
    .wdata (bus.in_data),
    .re    (rd_issue),
    .raddr (rd_ptr),
    .rdata (rdata)
  );

  // Buffer contents are never reset, so out_data is masked to zero while not valid.
  assign bus.out_data     = out_valid_q ? rdata : '0;
  assign bus.out_valid    = out_valid_q;
  assign bus.out_last     = out_last_q;
  assign bus.done         = done_q;
  assign bus.err_overflow = err_overflow_q;

endmodule

// File: tb/tb_poly_result_capture.sv
// Directed bench for poly_result_capture with a queue scoreboard of captured words.
// Words are pushed when driven into CAPTURE and popped on each output handshake.
// Range-check expectations follow POLY_CAPTURE_RANGE_CHECK_EN.
module tb_poly_result_capture;
  import poly_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  poly_result_capture_if bus ();

  poly_result_capture dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int     tests = 0;
  int     fails = 0;
  coeff_t sb [$];
  coeff_t vals [N];
  logic   exp_rng;
  addr_t  exp_idx;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic do_arm(input logic with_in);
    bus.arm      = 1'b1;
    bus.in_valid = with_in;
    bus.in_data  = 30'd777;
    tick();
    bus.arm      = 1'b0;
    bus.in_valid = 1'b0;
    chk("arm_busy", 32'(bus.busy), 1);
  endtask

  task automatic capture(input int count, input bit gaps);
    for (int i = 0; i < count; i++) begin
      if (gaps) begin
        bus.in_valid = 1'b0;
        tick();
      end
      bus.in_valid = 1'b1;
      bus.in_data  = vals[i];
      sb.push_back(vals[i]);
      tick();
      if (i == N - 2) chk("full_early", 32'(bus.full), 0);
    end
    bus.in_valid = 1'b0;
    if (count == N) chk("full_set", 32'(bus.full), 1);
  endtask

  task automatic drain_run(input int ready_pct, input int limit);
    int          hs = 0;
    int          idle = 0;
    int          cyc = 0;
    bit          stalled = 0;
    coeff_t      held = '0;
    logic        held_last = 1'b0;
    logic [31:0] exp;
    bus.drain = 1'b1;
    tick();
    bus.drain = 1'b0;
    chk("drain_lat1", 32'(bus.out_valid), 0);
    chk("full_drop", 32'(bus.full), 0);
    tick();
    chk("drain_lat2", 32'(bus.out_valid), 1);
    while (hs < limit && cyc < 20000) begin
      cyc++;
      if (stalled) begin
        chk("stall_valid", 32'(bus.out_valid), 1);
        chk("stall_data", 32'(bus.out_data), 32'(held));
        chk("stall_last", 32'(bus.out_last), 32'(held_last));
        stalled = 0;
      end
      bus.out_ready = ($urandom_range(99) < ready_pct);
      if (bus.out_valid) begin
        if (bus.out_ready) begin
          exp = (sb.size() > 0) ? 32'(sb.pop_front()) : 32'hdead_beef;
          chk("data", 32'(bus.out_data), exp);
          chk("last", 32'(bus.out_last), 32'(hs == N - 1));
          hs++;
        end else begin
          stalled   = 1;
          held      = bus.out_data;
          held_last = bus.out_last;
        end
      end else begin
        idle++;
      end
      tick();
    end
    bus.out_ready = 1'b0;
    if (cyc >= 20000) chk("drain_timeout", hs, limit);
    if (ready_pct == 100) chk("gapless", idle, 0);
    if (limit == N) begin
      chk("done_pulse", 32'(bus.done), 1);
      chk("idle_busy", 32'(bus.busy), 0);
      chk("idle_valid", 32'(bus.out_valid), 0);
      tick();
      chk("done_once", 32'(bus.done), 0);
    end
  endtask

  initial begin
`ifdef POLY_CAPTURE_RANGE_CHECK_EN
    exp_rng = 1'b1;
    exp_idx = 10'd5;
`else
    exp_rng = 1'b0;
    exp_idx = 10'd0;
`endif
    reset         = 1'b1;
    bus.arm       = 1'b0;
    bus.abort     = 1'b0;
    bus.drain     = 1'b0;
    bus.q         = 30'd12289;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;
    tick();
    tick();
    chk("rst_valid", 32'(bus.out_valid), 0);
    chk("rst_data", 32'(bus.out_data), 0);
    chk("rst_last", 32'(bus.out_last), 0);
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_full", 32'(bus.full), 0);
    chk("rst_done", 32'(bus.done), 0);
    chk("rst_ovf", 32'(bus.err_overflow), 0);
    chk("rst_rng", 32'(bus.err_range), 0);
    chk("rst_idx", 32'(bus.err_idx), 0);
    reset = 1'b0;
    tick();

    // Drain in IDLE has no effect.
    bus.drain = 1'b1;
    tick();
    bus.drain = 1'b0;
    tick();
    chk("idle_drain_valid", 32'(bus.out_valid), 0);
    chk("idle_drain_busy", 32'(bus.busy), 0);

    // Basic back-to-back capture and gapless drain.
    for (int i = 0; i < N; i++) vals[i] = coeff_t'(i);
    do_arm(1'b0);
    capture(N, 1'b0);
    drain_run(100, N);
    chk("sb_empty1", sb.size(), 0);

    // Gapped input, random backpressure, out-of-range words at 5 and 9.
    for (int i = 0; i < N; i++) vals[i] = coeff_t'((i * 37) % 12289);
    vals[5] = 30'd12289;
    vals[9] = 30'd20000;
    do_arm(1'b0);
    capture(N, 1'b1);
    chk("rng_flag", 32'(bus.err_range), 32'(exp_rng));
    chk("rng_idx", 32'(bus.err_idx), 32'(exp_idx));
    drain_run(50, N);
    chk("rng_sticky", 32'(bus.err_range), 32'(exp_rng));
    chk("idx_sticky", 32'(bus.err_idx), 32'(exp_idx));
    chk("sb_empty2", sb.size(), 0);

    // Overflow while FULL; buffer must come back untouched.
    for (int i = 0; i < N; i++) vals[i] = coeff_t'(i ^ 30'h2aaa);
    do_arm(1'b0);
    chk("rng_cleared", 32'(bus.err_range), 0);
    chk("idx_cleared", 32'(bus.err_idx), 0);
    capture(N, 1'b0);
    bus.in_valid = 1'b1;
    bus.in_data  = 30'd999;
    tick();
    bus.in_valid = 1'b0;
    chk("ovf_set", 32'(bus.err_overflow), 1);
    chk("ovf_full", 32'(bus.full), 1);
    drain_run(100, N);
    chk("ovf_sticky", 32'(bus.err_overflow), 1);
    chk("sb_empty3", sb.size(), 0);

    // Arm with a simultaneous word: word dropped, overflow ends up set; then abort.
    for (int i = 0; i < N; i++) vals[i] = coeff_t'(i + 100);
    do_arm(1'b1);
    chk("arm_ovf_net", 32'(bus.err_overflow), 1);
    capture(300, 1'b0);
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    chk("abort_busy", 32'(bus.busy), 0);
    chk("abort_done", 32'(bus.done), 0);
    chk("abort_ovf_kept", 32'(bus.err_overflow), 1);
    tick();
    chk("abort_done2", 32'(bus.done), 0);
    sb.delete();
    do_arm(1'b0);
    chk("arm_clr_ovf", 32'(bus.err_overflow), 0);
    for (int i = 0; i < N; i++) vals[i] = coeff_t'(5000 + i);
    capture(N, 1'b0);
    drain_run(100, N);
    chk("sb_empty4", sb.size(), 0);

    // Reset in the middle of a drain.
    for (int i = 0; i < N; i++) vals[i] = coeff_t'(N - 1 - i);
    do_arm(1'b0);
    capture(N, 1'b0);
    drain_run(100, 100);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("mid_rst_valid", 32'(bus.out_valid), 0);
    chk("mid_rst_busy", 32'(bus.busy), 0);
    chk("mid_rst_full", 32'(bus.full), 0);
    chk("mid_rst_done", 32'(bus.done), 0);
    sb.delete();
    bus.drain = 1'b1;
    tick();
    bus.drain = 1'b0;
    tick();
    tick();
    chk("post_rst_drain_valid", 32'(bus.out_valid), 0);
    chk("post_rst_drain_busy", 32'(bus.busy), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/poly_result_capture.md
Name: poly_result_capture

Overview:
- Downstream stage of the coefficient-wise modular adder.
- Captures one N-coefficient result polynomial, streamed one coefficient per cycle, into a local buffer.
- Replays the buffer to the next consumer (NTT / memory writer) over a valid/ready stream.
- Optionally range-checks every captured coefficient against q.

Parameters:
- N, 1024, coefficients per polynomial (power of two)
- COEFF_W, 30, coefficient and modulus width
- ADDR_W, 10, log2(N)

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- arm  in  1  one-cycle pulse; start a new capture
- abort  in  1  return to IDLE from any state
- in_valid  in  1  in_data holds a valid coefficient this cycle
- in_data  in  COEFF_W  coefficient from the adder
- q  in  COEFF_W  modulus; stable while busy
- drain  in  1  one-cycle pulse; start replay of a full buffer
- out_valid  out  1  out_data valid
- out_ready  in  1  consumer accepts out_data
- out_data  out  COEFF_W  replayed coefficient
- out_last  out  1  high with coefficient N-1
- busy  out  1  high in CAPTURE, FULL, DRAIN
- full  out  1  high in FULL
- done  out  1  one-cycle pulse after the last output handshake
- err_overflow  out  1  sticky: in_valid seen outside CAPTURE
- err_range  out  1  sticky: captured coefficient >= q
- err_idx  out  ADDR_W  index of the first out-of-range coefficient

Behaviour:
- Clock and reset: single clock clk. reset is synchronous and active-high.
- Reset values: every output 0; state IDLE; wr_ptr and rd_ptr 0. Buffer contents are not cleared.
- States: IDLE, CAPTURE, FULL, DRAIN.
- IDLE:
  - arm -> CAPTURE next cycle.
  - arm clears err_overflow, err_range and err_idx.
- CAPTURE:
  - Each cycle with in_valid: mem[wr_ptr] <= in_data; wr_ptr++.
  - Cycles without in_valid are gaps; the capture holds and waits.
  - The write with wr_ptr == N-1 wraps wr_ptr to 0 and moves to FULL. full = 1 the next cycle.
- FULL:
  - Hold the buffer.
  - drain -> DRAIN next cycle; full drops the same cycle DRAIN is entered.
- DRAIN:
  - Memory has 1-cycle read latency. A prefetch/skid register gives sustained 1 word/cycle while out_ready is held high.
  - First out_valid appears exactly 2 cycles after the drain pulse.
  - out_data and out_last hold stable while out_valid && !out_ready.
  - A handshake (out_valid && out_ready) on index N-1 -> IDLE next cycle, with done = 1 for exactly that cycle.
- Ignored inputs:
  - arm outside IDLE, drain outside FULL: no effect.
  - in_valid outside CAPTURE: data dropped, err_overflow set.
- Priority: reset > abort > all else.
  - abort forces IDLE and zeroes pointers, out_valid and full.
  - abort does not generate done and does not clear the error flags.
- Simultaneous events:
  - arm and in_valid in the same IDLE cycle: that word is not captured, and err_overflow is set after the clear (net result: set).
  - The last capture write and drain in the same cycle: drain is ignored.
- Comparison is unsigned, COEFF_W bits.

Optional Feature:
- Macro: POLY_CAPTURE_RANGE_CHECK_EN.
- Defined:
  - Each captured word is compared with in_data >= q.
  - The first violation sets err_range and latches its index into err_idx.
  - Later violations do not change err_idx.
- Undefined:
  - No comparator is built.
  - err_range and err_idx are tied to 0.

Decomposition:
- Shared package (poly_pkg):
  - COEFF_W, N and ADDR_W constants.
  - The coeff_t typedef.
  - The capture state enum.
- Sub-module coeff_buffer_1r1w:
  - Simple dual-port memory, N x COEFF_W, registered read, 1-cycle latency.
  - Infers BRAM; no reset on the array.

Test Plan:
- Basic capture and drain:
  - Stimulus: reset, arm, stream 0..1023 back-to-back (q=12289), drain, out_ready=1.
  - Response: out_data 0..1023 in order, out_last on 1023, done 1 cycle after that handshake, 1024 consecutive valid cycles.
- Input gaps and output backpressure:
  - Stimulus: in_valid toggled every other cycle; then out_ready random at 50%.
  - Response: identical data order; out_data stable while stalled; full asserted only after the 1024th write.
- Range check (macro defined):
  - Stimulus: q=12289; word 5 = 12289, word 9 = 20000.
  - Response: err_range=1, err_idx=5, both sticky until the next arm.
  - Same stimulus with macro undefined: err_range=0, err_idx=0.
- Overflow:
  - Stimulus: in_valid pulsed while in FULL.
  - Response: err_overflow=1; buffer unchanged on drain; a later arm clears the flag.
- Abort mid-capture:
  - Stimulus: abort after 300 words, then arm and a full new capture of values 5000+i.
  - Response: drain returns 5000..6023; no done pulse on the abort.
- Reset mid-drain:
  - Stimulus: reset after 100 output handshakes.
  - Response: next cycle out_valid=0, busy=0, full=0, state IDLE; drain ignored until a new capture completes.
